// File: rtl/uart_com_pkg.sv
// rtl/uart_com_pkg.sv - shared state encodings, line level and divider helper for uart_com
package uart_com_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rxd synchroniser plus bit-period counter producing the mid-bit sample strobe
module uart_rx_sampler #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  input  logic arm,
  input  logic active,
  output logic rxs,
  output logic sample_stb
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rxs        = sync_q[1];
  assign sample_stb = active && (cnt_q == '0);

  always_comb begin
    sync_d = {sync_q[0], rxd};
    cnt_d  = cnt_q;
    // Arming lands the first strobe mid start-bit; later strobes follow one bit apart.
    if (arm) begin
      cnt_d = HALF_M1;
    end else if (active) begin
      if (cnt_q == '0) cnt_d = FULL_M1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_com.sv
// rtl/uart_com.sv - full-duplex UART engine behind the memory controller COM registers
module uart_com
  import uart_com_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] com_data_out,
  input  logic       enable_com_write,
  input  logic       int_com_ack,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  output logic       com_write_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       rxd,
  output logic       txd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          txd_q, txd_d;
  logic          wr_rdy_q, wr_rdy_d;
  logic          tx_last;

  assign txd             = txd_q;
  assign com_write_ready = wr_rdy_q;
  assign tx_last         = (tx_cnt_q == FULL_M1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    txd_d      = txd_q;
    wr_rdy_d   = wr_rdy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (enable_com_write) begin
          tx_data_d  = com_data_out;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          wr_rdy_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_data_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          // Bit index wrapping back to 0 marks the end of the data bits.
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = LINE_IDLE;
          end else begin
            txd_d = tx_data_q[tx_bit_d];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          wr_rdy_d   = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      txd_q      <= LINE_IDLE;
      wr_rdy_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      txd_q      <= txd_d;
      wr_rdy_q   <= wr_rdy_d;
    end
  end

  rx_state_e  rx_state_q, rx_state_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rd_rdy_q, rd_rdy_d;
  logic       ovr_q, ovr_d;
  logic       fe_q, fe_d;
  logic       brk_q, brk_d;
  logic       rx_arm, rx_active, rxs, rx_stb, byte_done;

  assign rx_active      = (rx_state_q != RX_IDLE) && !brk_q;
  assign com_data_in    = rx_data_q;
  assign com_read_ready = rd_rdy_q;
  assign rx_overrun     = ovr_q;
  assign rx_frame_err   = fe_q;

  uart_rx_sampler #(
    .DIV(DIV)
  ) u_sampler (
    .clk        (clk50M),
    .rst        (rst),
    .rxd        (rxd),
    .arm        (rx_arm),
    .active     (rx_active),
    .rxs        (rxs),
    .sample_stb (rx_stb)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rd_rdy_d   = rd_rdy_q;
    ovr_d      = ovr_q;
    fe_d       = 1'b0;
    brk_d      = brk_q;
    rx_arm     = 1'b0;
    byte_done  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) begin
          rx_arm     = 1'b1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_stb) begin
          if (rxs) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_stb) begin
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // A zero stop bit is a break: hold here until the line returns high.
        if (brk_q) begin
          if (rxs) begin
            brk_d      = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_stb) begin
          if (rxs) begin
            byte_done  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            fe_d  = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (int_com_ack && rd_rdy_q) begin
      rd_rdy_d = 1'b0;
      ovr_d    = 1'b0;
    end
    // A new byte beats a same-cycle ack; it only counts as overrun when unacked.
    if (byte_done) begin
      rx_data_d = rx_shift_q;
      rd_rdy_d  = 1'b1;
      if (rd_rdy_q && !int_com_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rd_rdy_q   <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rd_rdy_q   <= rd_rdy_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      brk_q      <= brk_d;
    end
  end

endmodule

// File: tb/tb_uart_com.sv
// tb/tb_uart_com.sv - directed table-driven bench for uart_com at 16 clocks per bit
module tb_uart_com;

  logic       clk50M = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] com_data_out = 8'h00;
  logic       enable_com_write = 1'b0;
  logic       int_com_ack = 1'b0;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       com_write_ready;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rxd = 1'b1;
  logic       txd;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;

  uart_com #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .clk50M           (clk50M),
    .rst              (rst),
    .com_data_out     (com_data_out),
    .enable_com_write (enable_com_write),
    .int_com_ack      (int_com_ack),
    .com_data_in      (com_data_in),
    .com_read_ready   (com_read_ready),
    .com_write_ready  (com_write_ready),
    .rx_overrun       (rx_overrun),
    .rx_frame_err     (rx_frame_err),
    .rxd              (rxd),
    .txd              (txd)
  );

  always #5 clk50M = ~clk50M;

  always @(negedge clk50M) if (rx_frame_err) fe_cnt <= fe_cnt + 1;

  typedef struct {
    bit         is_rx;
    logic [7:0] data;
    logic       stop;
    logic [9:0] exp_frame;
    logic [7:0] exp_data;
    logic       exp_ready;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Starts on a negedge; returns the 10 mid-bit txd samples and how many cycles ready stayed low.
  task automatic tx_frame(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d,
                          output logic [9:0] frame, output int low_cnt);
    int c;
    frame = '0;
    low_cnt = 0;
    com_data_out = d;
    enable_com_write = 1'b1;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    c = 0;
    while (c < 400) begin
      if (c < 160 && (c % 16) == 8) frame[c / 16] = txd;
      if (com_write_ready) break;
      low_cnt++;
      if (c == inj_at) begin
        com_data_out = inj_d;
        enable_com_write = 1'b1;
      end else begin
        enable_com_write = 1'b0;
      end
      @(negedge clk50M);
      c++;
    end
    enable_com_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int cut);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 160; i++) begin
      if (i == cut) break;
      rxd = f[i / 16];
      @(negedge clk50M);
    end
    rxd = 1'b1;
  endtask

  task automatic do_ack();
    int_com_ack = 1'b1;
    @(negedge clk50M);
    int_com_ack = 1'b0;
    @(negedge clk50M);
  endtask

  initial begin
    logic [9:0] frame;
    int low_cnt, fe0, bad_tx;

    vecs[0] = '{1'b0, 8'hA5, 1'b1, 10'h34A, 8'h00, 1'b0, 0};
    vecs[1] = '{1'b0, 8'h3C, 1'b1, 10'h278, 8'h00, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 10'h200, 8'h00, 1'b0, 0};
    vecs[3] = '{1'b0, 8'hFF, 1'b1, 10'h3FE, 8'h00, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h5A, 1'b1, 10'h000, 8'h5A, 1'b1, 0};
    vecs[5] = '{1'b1, 8'hC3, 1'b0, 10'h000, 8'h5A, 1'b0, 1};
    vecs[6] = '{1'b1, 8'h00, 1'b1, 10'h000, 8'h00, 1'b1, 0};
    vecs[7] = '{1'b1, 8'hFF, 1'b1, 10'h000, 8'hFF, 1'b1, 0};

    repeat (3) @(negedge clk50M);
    check("reset txd", 32'(txd), 32'd1);
    check("reset write_ready", 32'(com_write_ready), 32'd1);
    check("reset read_ready", 32'(com_read_ready), 32'd0);
    check("reset data_in", 32'(com_data_in), 32'h00);
    check("reset overrun", 32'(rx_overrun), 32'd0);
    check("reset frame_err", 32'(rx_frame_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk50M);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].is_rx) begin
        tx_frame(vecs[i].data, -1, 8'h00, frame, low_cnt);
        check($sformatf("tx frame %0d", i), 32'(frame), 32'(vecs[i].exp_frame));
        check($sformatf("tx busy cycles %0d", i), 32'(low_cnt), 32'd160);
        repeat (2) @(negedge clk50M);
      end else begin
        fe0 = fe_cnt;
        send_rx(vecs[i].data, vecs[i].stop, -1);
        repeat (4) @(negedge clk50M);
        check($sformatf("rx data %0d", i), 32'(com_data_in), 32'(vecs[i].exp_data));
        check($sformatf("rx ready %0d", i), 32'(com_read_ready), 32'(vecs[i].exp_ready));
        check($sformatf("rx frame_err count %0d", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
        if (vecs[i].exp_ready) begin
          do_ack();
          check($sformatf("rx ack clears ready %0d", i), 32'(com_read_ready), 32'd0);
        end
      end
    end

    // Strobe during a frame must be dropped.
    tx_frame(8'hA5, 40, 8'h3C, frame, low_cnt);
    check("tx busy strobe frame", 32'(frame), 32'h34A);
    check("tx busy strobe length", 32'(low_cnt), 32'd160);
    bad_tx = 0;
    for (int i = 0; i < 48; i++) begin
      if (txd !== 1'b1 || com_write_ready !== 1'b1) bad_tx++;
      @(negedge clk50M);
    end
    check("tx no follow-on frame", 32'(bad_tx), 32'd0);

    // Short low glitch: no byte, no frame error.
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk50M);
    rxd = 1'b1;
    repeat (40) @(negedge clk50M);
    check("glitch ready", 32'(com_read_ready), 32'd0);
    check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch data", 32'(com_data_in), 32'hFF);

    // Overrun, then ack clears both flags.
    send_rx(8'h11, 1'b1, -1);
    send_rx(8'h22, 1'b1, -1);
    repeat (2) @(negedge clk50M);
    check("overrun data", 32'(com_data_in), 32'h22);
    check("overrun ready", 32'(com_read_ready), 32'd1);
    check("overrun flag", 32'(rx_overrun), 32'd1);
    do_ack();
    check("overrun ack ready", 32'(com_read_ready), 32'd0);
    check("overrun ack flag", 32'(rx_overrun), 32'd0);

    // Byte completing on the same edge as an ack wins without overrun.
    send_rx(8'h44, 1'b1, -1);
    fork
      send_rx(8'h66, 1'b1, -1);
      begin
        repeat (154) @(negedge clk50M);
        int_com_ack = 1'b1;
        @(negedge clk50M);
        int_com_ack = 1'b0;
      end
    join
    repeat (2) @(negedge clk50M);
    check("ack race data", 32'(com_data_in), 32'h66);
    check("ack race ready", 32'(com_read_ready), 32'd1);
    check("ack race overrun", 32'(rx_overrun), 32'd0);
    do_ack();

    // Full duplex.
    fork
      tx_frame(8'hC3, -1, 8'h00, frame, low_cnt);
      send_rx(8'h96, 1'b1, -1);
    join
    repeat (4) @(negedge clk50M);
    check("duplex tx frame", 32'(frame), 32'h386);
    check("duplex tx length", 32'(low_cnt), 32'd160);
    check("duplex rx data", 32'(com_data_in), 32'h96);
    check("duplex rx ready", 32'(com_read_ready), 32'd1);
    do_ack();

    // Reset 70 cycles into a TX frame.
    com_data_out = 8'hA5;
    enable_com_write = 1'b1;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    repeat (69) @(negedge clk50M);
    check("tx busy before reset", 32'(com_write_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("tx reset txd", 32'(txd), 32'd1);
    check("tx reset write_ready", 32'(com_write_ready), 32'd1);
    @(negedge clk50M);
    rst = 1'b0;
    bad_tx = 0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) bad_tx++;
      @(negedge clk50M);
    end
    check("tx idle after reset", 32'(bad_tx), 32'd0);
    tx_frame(8'h5A, -1, 8'h00, frame, low_cnt);
    check("tx frame after reset", 32'(frame), 32'h2B4);

    // Reset 70 cycles into an RX frame.
    send_rx(8'h81, 1'b1, 70);
    rst = 1'b1;
    #1;
    check("rx reset ready", 32'(com_read_ready), 32'd0);
    check("rx reset data", 32'(com_data_in), 32'h00);
    @(negedge clk50M);
    rst = 1'b0;
    repeat (200) @(negedge clk50M);
    check("rx no partial byte", 32'(com_read_ready), 32'd0);
    send_rx(8'h81, 1'b1, -1);
    repeat (4) @(negedge clk50M);
    check("rx clean after reset data", 32'(com_data_in), 32'h81);
    check("rx clean after reset ready", 32'(com_read_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
